wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone classic arbiter between the core-side bus masters and the single `core_*` memory port of `processorci_top`. It lets cores with separate instruction and data Wishbone masters share one Controller memory port when `ENABLE_SECOND_MEMORY` is not defined. Arbitration is round-robin or fixed-priority. Ownership is held for the whole `cyc` assertion. A per-grant watchdog reports a bus error if the slave never acknowledges.

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_arbiter_2m.sv | 157 +++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types for the two-master Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWN0   = 3'd1,
    OWN1   = 3'd2,
    DRAIN0 = 3'd3,
    DRAIN1 = 3'd4
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

endpackage

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master Wishbone classic arbiter with per-grant watchdog
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_core,
  input  logic        rst_core,

  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_out,
  output logic [31:0] m0_data_in,
  output logic        m0_ack,
  output logic        m0_err,

  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_out,
  output logic [31:0] m1_data_in,
  output logic        m1_ack,
  output logic        m1_err,

  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_out,
  input  logic [31:0] s_data_in,
  input  logic        s_ack
);

  arb_state_t state_q, state_d;
  mst_idx_t   last_grant_q, last_grant_d;
  logic       req0, req1, own0, own1, grant, timeout_hit;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;
  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_wstrb    = 4'b0;
    s_addr     = 32'b0;
    s_data_out = 32'b0;
    if (own0) begin
      s_cyc      = m0_cyc;
      s_stb      = m0_stb;
      s_we       = m0_we;
      s_wstrb    = m0_wstrb;
      s_addr     = m0_addr;
      s_data_out = m0_data_out;
    end else if (own1) begin
      s_cyc      = m1_cyc;
      s_stb      = m1_stb;
      s_we       = m1_we;
      s_wstrb    = m1_wstrb;
      s_addr     = m1_addr;
      s_data_out = m1_data_out;
    end
  end

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_data_in = s_data_in;
  assign m1_data_in = s_data_in;
  assign m0_ack     = own0 & s_ack;
  assign m1_ack     = own1 & s_ack;
  assign m0_err     = own0 & timeout_hit;
  assign m1_err     = own1 & timeout_hit;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          grant = 1'b1;
          if ((FIXED_PRIORITY != 0) || (last_grant_q == MST1)) begin
            state_d      = OWN0;
            last_grant_d = MST0;
          end else begin
            state_d      = OWN1;
            last_grant_d = MST1;
          end
        end else if (req0) begin
          grant        = 1'b1;
          state_d      = OWN0;
          last_grant_d = MST0;
        end else if (req1) begin
          grant        = 1'b1;
          state_d      = OWN1;
          last_grant_d = MST1;
        end
      end
      OWN0: begin
        if (!m0_cyc)          state_d = IDLE;
        else if (timeout_hit) state_d = DRAIN0;
      end
      OWN1: begin
        if (!m1_cyc)          state_d = IDLE;
        else if (timeout_hit) state_d = DRAIN1;
      end
      DRAIN0:  if (!m0_cyc) state_d = IDLE;
      DRAIN1:  if (!m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q      <= IDLE;
      last_grant_q <= MST1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Counts strobed cycles without ack since the grant or the last ack.
      always_comb begin
        cnt_d = cnt_q;
        if (grant || s_ack)            cnt_d = '0;
        else if ((own0 || own1) && s_stb) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_core) begin
        if (rst_core) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end

      // An ack on the final cycle wins over the timeout.
      assign timeout_hit = (own0 || own1) && s_cyc && s_stb && !s_ack && (cnt_q == LAST);
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed and randomized checks of wb_arbiter_2m against a reference model
module tb_wb_arbiter_2m;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_data_out, m1_addr, m1_data_out, s_data_in;

  logic        a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic [3:0]  a_s_wstrb;
  logic [31:0] a_s_addr, a_s_data_out, a_m0_data_in, a_m1_data_in;
  logic        b_s_cyc, b_s_stb, b_s_we, b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [3:0]  b_s_wstrb;
  logic [31:0] b_s_addr, b_s_data_out, b_m0_data_in, b_m1_data_in;

  int total = 0;
  int bad   = 0;

  always #5 clk_core = ~clk_core;

  // Instance a: round-robin with an 8-cycle watchdog; instance b: fixed priority, no watchdog.
  wb_arbiter_2m #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_in(a_m0_data_in),
    .m0_ack(a_m0_ack), .m0_err(a_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_in(a_m1_data_in),
    .m1_ack(a_m1_ack), .m1_err(a_m1_err),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_wstrb(a_s_wstrb),
    .s_addr(a_s_addr), .s_data_out(a_s_data_out), .s_data_in(s_data_in), .s_ack(s_ack)
  );

  wb_arbiter_2m #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(0)) dut_fp (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_in(b_m0_data_in),
    .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_in(b_m1_data_in),
    .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_wstrb(b_s_wstrb),
    .s_addr(b_s_addr), .s_data_out(b_s_data_out), .s_data_in(s_data_in), .s_ack(s_ack)
  );

  wire [138:0] a_obs = {a_s_cyc, a_s_stb, a_s_we, a_s_wstrb, a_s_addr, a_s_data_out,
                        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_m0_data_in, a_m1_data_in};
  wire [138:0] b_obs = {b_s_cyc, b_s_stb, b_s_we, b_s_wstrb, b_s_addr, b_s_data_out,
                        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_m0_data_in, b_m1_data_in};

  // Reference model: owner (-1 = nobody), draining flag, last winner, strobes-without-ack.
  int owner[2]    = '{-1, -1};
  bit draining[2] = '{1'b0, 1'b0};
  int last_win[2] = '{1, 1};
  int waited[2]   = '{0, 0};
  int fixed_pr[2] = '{0, 1};
  int limit[2]    = '{8, 0};

  function automatic bit owner_cyc(int i);
    return (owner[i] == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic bit owner_stb(int i);
    return (owner[i] == 0) ? m0_stb : m1_stb;
  endfunction

  function automatic bit times_out(int i);
    if (limit[i] == 0 || owner[i] < 0 || draining[i] || s_ack) return 1'b0;
    return owner_cyc(i) && owner_stb(i) && (waited[i] == limit[i] - 1);
  endfunction

  function automatic logic [138:0] model_out(int i);
    logic [74:0] ctl = '0;
    if (owner[i] == 0 && !draining[i])
      ctl = {m0_cyc, m0_stb, m0_we, m0_wstrb, m0_addr, m0_data_out, s_ack, times_out(i), 2'b00};
    else if (owner[i] == 1 && !draining[i])
      ctl = {m1_cyc, m1_stb, m1_we, m1_wstrb, m1_addr, m1_data_out, 2'b00, s_ack, times_out(i)};
    return {ctl, s_data_in, s_data_in};
  endfunction

  task automatic model_step(int i);
    bit r0, r1, t;
    r0 = m0_cyc && m0_stb;
    r1 = m1_cyc && m1_stb;
    t  = times_out(i);
    if (rst_core) begin
      owner[i] = -1; draining[i] = 1'b0; last_win[i] = 1; waited[i] = 0;
    end else if (owner[i] < 0) begin
      if (r0 && r1) owner[i] = (fixed_pr[i] != 0 || last_win[i] == 1) ? 0 : 1;
      else if (r0)  owner[i] = 0;
      else if (r1)  owner[i] = 1;
      if (owner[i] >= 0) begin
        last_win[i] = owner[i];
        waited[i]   = 0;
      end
    end else if (!owner_cyc(i)) begin
      owner[i] = -1;
      draining[i] = 1'b0;
    end else if (!draining[i]) begin
      if (t) draining[i] = 1'b1;
      if (s_ack) waited[i] = 0;
      else if (owner_stb(i)) waited[i]++;
    end
  endtask

  task automatic chk(string tag, logic [138:0] obs, logic [138:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_core);
    chk("model_rr", a_obs, model_out(0));
    chk("model_fp", b_obs, model_out(1));
    @(posedge clk_core);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
  endtask

  initial begin
    rst_core = 1; idle_masters();
    m0_we = 0; m1_we = 0; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
    m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_1000;
    m0_data_out = 32'h1111_0000; m1_data_out = 32'h2222_0000; s_data_in = 32'h5A5A_A5A5;
    tick(); tick();
    look();
    chk("reset_outputs", a_obs, {75'b0, s_data_in, s_data_in});

    // Reset sweep: reset while m1 owns and the slave acks.
    rst_core = 0; m1_cyc = 1; m1_stb = 1;
    tick();
    look();
    chk("own1_cyc", 139'(a_s_cyc), 139'(1'b1));
    s_ack = 1; rst_core = 1;
    tick();
    rst_core = 0; m0_cyc = 1; m0_stb = 1;
    look();
    chk("rst_clear", a_obs, {75'b0, s_data_in, s_data_in});
    s_ack = 0;
    tick();
    look();
    chk("rst_tie_m0", 139'(a_s_addr), 139'(m0_addr));
    idle_masters();
    tick(); tick();

    // Single read by m1 with a one-cycle slave.
    m1_cyc = 1; m1_stb = 1; m1_we = 0;
    tick();
    look();
    chk("m1_stb_up", 139'(a_s_stb), 139'(1'b1));
    tick();
    s_ack = 1; s_data_in = 32'hDEAD_BEEF;
    look();
    chk("m1_ack", 139'(a_m1_ack), 139'(1'b1));
    chk("m1_rdata", 139'(a_m1_data_in), 139'(32'hDEAD_BEEF));
    chk("m0_ack_quiet", 139'(a_m0_ack), 139'(1'b0));
    tick();
    idle_masters();
    tick(); tick();

    // Tie arbitration from a fresh reset.
    rst_core = 1; tick(); rst_core = 0;
    for (int g = 0; g < 6; g++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 0;
      tick();
      s_ack = 1;
      look();
      chk("rr_grant", 139'(a_m0_ack), 139'(g % 2 == 0));
      chk("fp_grant", 139'(b_m0_ack), 139'(1'b1));
      tick();
      idle_masters();
      tick();
    end

    // Burst hold: m0 keeps cyc across 4 beats while m1 waits.
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_wstrb = 4'b0011;
    tick();
    m1_cyc = 1; m1_stb = 1;
    for (int b = 0; b < 4; b++) begin
      m0_stb = 1; s_ack = 1; m0_data_out = 32'hB000_0000 + b;
      look();
      chk("burst_ack", 139'(a_m0_ack), 139'(1'b1));
      chk("burst_wstrb", 139'(a_s_wstrb), 139'(4'b0011));
      chk("burst_m1_quiet", 139'(a_m1_ack), 139'(1'b0));
      tick();
      m0_stb = 0; s_ack = 0;
      look();
      chk("burst_hold", 139'(a_s_addr), 139'(m0_addr));
      tick();
    end
    m0_cyc = 0; m0_we = 0; m0_wstrb = 4'hF;
    tick();
    look();
    chk("turn_idle", 139'(a_s_cyc), 139'(1'b0));
    tick();
    look();
    chk("m1_after_burst", 139'({a_s_cyc, a_s_addr}), 139'({1'b1, m1_addr}));
    idle_masters();
    tick(); tick();

    // Watchdog: slave never acks.
    rst_core = 1; tick(); rst_core = 0;
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      look();
      chk("tmo_err", 139'(a_m0_err), 139'(k == 8));
      chk("tmo_stb", 139'(a_s_stb), 139'(1'b1));
      tick();
    end
    look();
    chk("drain_cyc", 139'(a_s_cyc), 139'(1'b0));
    tick();
    s_ack = 1;
    look();
    chk("late_ack", 139'({a_m0_ack, a_s_cyc}), 139'(2'b00));
    tick();
    idle_masters();
    tick(); tick();

    // Ack arriving on the timeout cycle.
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ack = 1;
    look();
    chk("coll_ack", 139'(a_m0_ack), 139'(1'b1));
    chk("coll_err", 139'(a_m0_err), 139'(1'b0));
    tick();
    s_ack = 0;
    look();
    chk("coll_own", 139'(a_s_cyc), 139'(1'b1));
    tick();
    idle_masters();
    tick(); tick();

    // Randomized traffic; slow windows with no acks exercise the watchdog.
    for (int n = 0; n < 3000; n++) begin
      rst_core = ($urandom_range(299) == 0);
      if ($urandom_range(5) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(5) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc && ($urandom_range(3) != 0);
      m1_stb = m1_cyc && ($urandom_range(3) != 0);
      m0_we = $urandom_range(1) == 1; m1_we = $urandom_range(1) == 1;
      m0_wstrb = 4'($urandom); m1_wstrb = 4'($urandom);
      m0_addr = $urandom; m1_addr = $urandom;
      m0_data_out = $urandom; m1_data_out = $urandom; s_data_in = $urandom;
      s_ack = ((n / 80) % 2 == 1) ? 1'b0 : ($urandom_range(2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
